// File: rtl/aes_pkg.sv
// Shared definitions for the AES round sequencer: FSM states, index widths
// and the round / key-schedule size helpers derived from the key length.
package aes_pkg;

  localparam int KIDX_W = 6;
  localparam int RIDX_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    KEYEXP,
    INIT,
    ROUND,
    FINAL,
    DONE
  } state_t;

  function automatic int NR_OF(input int nk);
    return nk + 6;
  endfunction

  function automatic int NW_OF(input int nk);
    return 4 * (nk + 7);
  endfunction

endpackage

// File: rtl/aes_step_counter.sv
// Loadable up-counter that stops at LAST and flags it, so an index never
// wraps past the end of the key schedule or the round sequence.
module aes_step_counter #(
  parameter int W    = 6,
  parameter int LAST = 43
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == W'(LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (step && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-encrypt sequencer: key expansion, rounds 0..Nr, ciphertext
// hand-off. Define AES_KEY_REUSE_EN to skip key expansion for an unchanged key.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int Nk = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              key_new,
  output logic              busy,
  output logic              kexp_en,
  output logic [KIDX_W-1:0] kexp_idx,
  output logic              rnd_en,
  output logic [RIDX_W-1:0] rnd_idx,
  output logic              rnd_first,
  output logic              rnd_last,
  output logic              ct_load,
  output logic              out_valid,
  input  logic              out_ack
);

  localparam int Nr = NR_OF(Nk);
  localparam int NW = NW_OF(Nk);
  localparam logic [RIDX_W-1:0] RND_PEN = RIDX_W'(Nr - 1);

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_round_ctrl: Nk must be 4, 6 or 8");
  end

  state_t state;
  logic   idle_start, take_skip;
  logic   kexp_load, kexp_step, kexp_tc;
  logic   rnd_load, rnd_step, unused_rnd_tc;

`ifdef AES_KEY_REUSE_EN
  logic sched_vld;
  assign take_skip = !key_new && sched_vld;
`else
  logic unused_key_new;
  assign unused_key_new = key_new;
  assign take_skip      = 1'b0;
`endif

  assign idle_start = (state == IDLE) && start;
  assign kexp_load  = idle_start && !take_skip;
  assign kexp_step  = (state == KEYEXP) && !kexp_tc;
  assign rnd_load   = (idle_start && take_skip) || ((state == KEYEXP) && kexp_tc);
  assign rnd_step   = (state == INIT) || (state == ROUND);

  aes_step_counter #(.W(KIDX_W), .LAST(NW - 1)) u_kexp_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (kexp_load),
    .load_val (KIDX_W'(Nk)),
    .step     (kexp_step),
    .count    (kexp_idx),
    .tc       (kexp_tc)
  );

  aes_step_counter #(.W(RIDX_W), .LAST(Nr)) u_rnd_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (rnd_load),
    .load_val ('0),
    .step     (rnd_step),
    .count    (rnd_idx),
    .tc       (unused_rnd_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      kexp_en   <= 1'b0;
      rnd_en    <= 1'b0;
      rnd_first <= 1'b0;
      rnd_last  <= 1'b0;
      ct_load   <= 1'b0;
      out_valid <= 1'b0;
`ifdef AES_KEY_REUSE_EN
      sched_vld <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (take_skip) begin
              state     <= INIT;
              rnd_en    <= 1'b1;
              rnd_first <= 1'b1;
            end else begin
              state   <= KEYEXP;
              kexp_en <= 1'b1;
            end
`ifdef AES_KEY_REUSE_EN
            if (key_new) sched_vld <= 1'b0;
`endif
          end
        end
        KEYEXP: begin
          if (kexp_tc) begin
            state     <= INIT;
            kexp_en   <= 1'b0;
            rnd_en    <= 1'b1;
            rnd_first <= 1'b1;
`ifdef AES_KEY_REUSE_EN
            sched_vld <= 1'b1;
`endif
          end
        end
        INIT: begin
          state     <= ROUND;
          rnd_first <= 1'b0;
        end
        ROUND: begin
          // The counter advances to Nr on this edge, so FINAL sees rnd_idx=Nr.
          if (rnd_idx == RND_PEN) begin
            state    <= FINAL;
            rnd_last <= 1'b1;
          end
        end
        FINAL: begin
          state     <= DONE;
          rnd_en    <= 1'b0;
          rnd_last  <= 1'b0;
          ct_load   <= 1'b1;
          out_valid <= 1'b1;
        end
        DONE: begin
          ct_load <= 1'b0;
          if (out_ack) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: Nk=4 and Nk=8 instances, every cycle of every run
// compared with a timeline computed from start offset, key length and ack delay.
module tb_aes_round_ctrl;

`ifdef AES_KEY_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, key_new, out_ack;
  int   sel;
  int   errors = 0;
  int   checks = 0;
  bit   mon_on = 1'b0;
  bit   flag[2];
  int   ct_cnt[2];
  int   runs_done[2];

  logic       busy_a, kexp_en_a, rnd_en_a, rnd_first_a, rnd_last_a, ct_load_a, out_valid_a;
  logic [5:0] kexp_idx_a;
  logic [3:0] rnd_idx_a;
  logic       busy_b, kexp_en_b, rnd_en_b, rnd_first_b, rnd_last_b, ct_load_b, out_valid_b;
  logic [5:0] kexp_idx_b;
  logic [3:0] rnd_idx_b;

  always #5 clk = ~clk;

  aes_round_ctrl #(.Nk(4)) u_nk4 (
    .clk(clk), .rst(rst), .start(start && sel == 0), .key_new(key_new),
    .busy(busy_a), .kexp_en(kexp_en_a), .kexp_idx(kexp_idx_a),
    .rnd_en(rnd_en_a), .rnd_idx(rnd_idx_a), .rnd_first(rnd_first_a),
    .rnd_last(rnd_last_a), .ct_load(ct_load_a), .out_valid(out_valid_a),
    .out_ack(out_ack && sel == 0)
  );

  aes_round_ctrl #(.Nk(8)) u_nk8 (
    .clk(clk), .rst(rst), .start(start && sel == 1), .key_new(key_new),
    .busy(busy_b), .kexp_en(kexp_en_b), .kexp_idx(kexp_idx_b),
    .rnd_en(rnd_en_b), .rnd_idx(rnd_idx_b), .rnd_first(rnd_first_b),
    .rnd_last(rnd_last_b), .ct_load(ct_load_b), .out_valid(out_valid_b),
    .out_ack(out_ack && sel == 1)
  );

  // {busy, kexp_en, kexp_idx[5:0], rnd_en, rnd_idx[3:0], rnd_first, rnd_last, ct_load, out_valid}
  function automatic logic [16:0] obs_of(input int s);
    if (s == 0)
      return {busy_a, kexp_en_a, kexp_idx_a, rnd_en_a, rnd_idx_a,
              rnd_first_a, rnd_last_a, ct_load_a, out_valid_a};
    return {busy_b, kexp_en_b, kexp_idx_b, rnd_en_b, rnd_idx_b,
            rnd_first_b, rnd_last_b, ct_load_b, out_valid_b};
  endfunction

  // Expected outputs k cycles after the start cycle, from the schedule rules.
  function automatic logic [16:0] expect_at(input int nk, input bit skip, input int ad, input int k);
    int nr, kw, l, r, kidx, ridx;
    bit ken, ren;
    nr   = nk + 6;
    kw   = skip ? 0 : 4 * (nk + 7) - nk;
    l    = kw + nr + 2;
    r    = k - kw - 1;
    ken  = (k >= 1) && (k <= kw);
    ren  = (r >= 0) && (r <= nr);
    kidx = ken ? nk + k - 1 : 0;
    ridx = ren ? r : 0;
    return {(k >= 1) && (k <= l + ad), ken, 6'(kidx), ren, 4'(ridx),
            ren && (r == 0), ren && (r == nr), k == l, (k >= l) && (k <= l + ad)};
  endfunction

  function automatic logic [16:0] masked(input logic [16:0] o, input logic [16:0] e);
    logic [16:0] m;
    m = o;
    if (!e[15]) m[14:9] = '0;
    if (!e[8])  m[7:4]  = '0;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [16:0] o, input logic [16:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start   = 1'b0;
      out_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk($sformatf("idle sel%0d", sel), masked(obs_of(sel), '0), '0);
    end
    out_ack = 1'b0;
  endtask

  // Runs one request on the selected instance; abort_at>0 pulses rst in that cycle.
  task automatic run(input bit kn, input int ad, input bit poke_done, input int abort_at);
    int nk, l, last;
    bit skip;
    logic [16:0] e;
    nk   = (sel == 0) ? 4 : 8;
    skip = REUSE && !kn && flag[sel];
    l    = (skip ? 0 : 4 * (nk + 7) - nk) + nk + 8;
    last = l + ad + 1;
    start   = 1'b1;
    key_new = kn;
    out_ack = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= last; k++) begin
      e = expect_at(nk, skip, ad, k);
      chk($sformatf("nk%0d kn%0d k=%0d", nk, kn, k), masked(obs_of(sel), e), e);
      if (k == abort_at) begin
        rst = 1'b1; start = 1'b0; out_ack = 1'b0;
        @(negedge clk);
        chk($sformatf("abort nk%0d", nk), obs_of(sel), '0);
        rst  = 1'b0;
        flag = '{1'b0, 1'b0};
        return;
      end
      if (k == last) break;
      start   = (poke_done && k == l + 1) || (k < l && $urandom_range(0, 7) == 0);
      key_new = 1'($urandom_range(0, 1));
      out_ack = (k == l + ad) ? 1'b1 : (k < l ? 1'($urandom_range(0, 1)) : 1'b0);
      @(negedge clk);
    end
    start   = 1'b0;
    out_ack = 1'b0;
    if (REUSE && kn) flag[sel] = 1'b0;
    if (REUSE && !skip) flag[sel] = 1'b1;
    runs_done[sel]++;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      checks++;
      assert (!(kexp_en_a && rnd_en_a) && !(kexp_en_b && rnd_en_b) &&
              !(rnd_first_a && rnd_last_a) && !(rnd_first_b && rnd_last_b)) else begin
        errors++;
        $error("FAIL exclusion: a=%b%b%b%b b=%b%b%b%b required no overlapping pair",
               kexp_en_a, rnd_en_a, rnd_first_a, rnd_last_a,
               kexp_en_b, rnd_en_b, rnd_first_b, rnd_last_b);
      end
      if (ct_load_a) ct_cnt[0]++;
      if (ct_load_b) ct_cnt[1]++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; key_new = 1'b0; out_ack = 1'b0; sel = 0;
    flag = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);
    chk("reset nk4", obs_of(0), '0);
    chk("reset nk8", obs_of(1), '0);
    rst    = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);

    sel = 0;
    run(1'b1, 0, 1'b0, 0);        // ack on DONE entry
    run(1'b1, 5, 1'b1, 0);        // back-to-back start, ack held off, start in DONE
    idle(2);
    run(1'b1, 2, 1'b0, 20);       // reset during key expansion
    idle(1);
    run(1'b1, 1, 1'b0, 0);
    run(1'b0, 0, 1'b0, 0);        // key reuse when enabled
    idle(1);
    run(1'b1, 0, 1'b0, 0);

    sel = 1;
    idle(1);
    run(1'b1, 1, 1'b0, 0);
    run(1'b0, 2, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      sel = int'($urandom_range(0, 1));
      run(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
      idle(int'($urandom_range(0, 2)));
    end

    sel = 0;
    idle(2);
    chk("ct_load count nk4", 17'(ct_cnt[0]), 17'(runs_done[0]));
    chk("ct_load count nk8", 17'(ct_cnt[1]), 17'(runs_done[1]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
